// File: rtl/move_scheduler.sv
// move_scheduler: queues manual moves, generates LFSR scramble moves, and issues them over valid/ready.
module move_scheduler #(
   parameter int          DEPTH      = 4,
   parameter int          SCRAMBLE_N = 16,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk_d,
   input  logic       rst,
   input  logic [1:0] game_status,
   input  logic [3:0] act_flag,
   input  logic       random_sw,
   input  logic       mv_ready,
   output logic       mv_valid,
   output logic [1:0] mv_dir,
   output logic       mv_scramble,
   output logic       scramble_done,
   output logic [7:0] step_number,
   output logic       q_ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [2:0] IDLE = 3'd0, INIT_ENTRY = 3'd1, SCRAMBLE = 3'd2, SCR_DONE = 3'd3, PLAY = 3'd4, WON = 3'd5;
   logic [2:0]    state, state_n;
   logic [1:0]    st_q;
   logic          chg;
   logic [15:0]   lfsr;
   logic [7:0]    scnt;
   logic [1:0]    prev_dir, scr_dir, req_dir, od;
   logic          prev_v, ov;
   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          hs_s, hs_p, push_req, push, pop, full, flush;

   always_ff @(posedge clk_d or negedge rst)
      if (!rst) begin
         state <= IDLE;
         st_q  <= 2'b00;
      end else begin
         state <= state_n;
         st_q  <= game_status;
      end

   // A status change always wins; status 10 runs its own small sub-sequence.
   always_comb begin
      chg     = game_status != st_q;
      state_n = state;
      case (game_status)
         2'b00:   state_n = IDLE;
         2'b01:   state_n = PLAY;
         2'b11:   state_n = WON;
         default: state_n = chg ? INIT_ENTRY :
                            state == INIT_ENTRY ? (random_sw ? SCRAMBLE : SCR_DONE) :
                            (state == SCRAMBLE && scnt == '0) ? SCR_DONE : state;
      endcase
   end

   always_comb begin
      scr_dir       = (prev_v && lfsr[1:0] == (prev_dir ^ 2'b01)) ? lfsr[1:0] ^ 2'b10 : lfsr[1:0];
      mv_scramble   = state == SCRAMBLE && scnt != '0;
      mv_valid      = mv_scramble || (state == PLAY && ov);
      mv_dir        = mv_scramble ? scr_dir : (state == PLAY ? od : 2'b00);
      scramble_done = state == SCR_DONE;
      hs_s          = mv_scramble && mv_ready;
      hs_p          = state == PLAY && ov && mv_ready;
      full          = (cnt + {{AW{1'b0}}, ov}) == (AW+1)'(DEPTH);
      req_dir       = act_flag[0] ? 2'd0 : act_flag[1] ? 2'd1 : act_flag[2] ? 2'd2 : 2'd3;
      push_req      = state == PLAY && !chg && |act_flag;
      flush         = chg || state != PLAY;
      pop           = cnt != '0 && (!ov || hs_p);
      push          = push_req && (!full || hs_p);
   end

   always_ff @(posedge clk_d)
      if (push) mem[wp] <= req_dir;

   // The output register counts toward capacity, so DEPTH moves fit in total.
   always_ff @(posedge clk_d or negedge rst)
      if (!rst) begin
         lfsr        <= LFSR_SEED;
         scnt        <= '0;
         prev_dir    <= 2'b00;
         prev_v      <= 1'b0;
         wp          <= '0;
         rp          <= '0;
         cnt         <= '0;
         ov          <= 1'b0;
         od          <= 2'b00;
         step_number <= '0;
         q_ovf       <= 1'b0;
      end else begin
         if (state == INIT_ENTRY) begin
            scnt   <= 8'(SCRAMBLE_N);
            prev_v <= 1'b0;
         end else if (hs_s) begin
            scnt     <= scnt - 1'b1;
            prev_dir <= scr_dir;
            prev_v   <= 1'b1;
            lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         end
         if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ov  <= 1'b0;
         end else begin
            wp  <= wp + AW'(push);
            rp  <= rp + AW'(pop);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            ov  <= pop | (ov & ~hs_p);
            if (pop) od <= mem[rp];
         end
         step_number <= (state_n == IDLE || state_n == INIT_ENTRY) ? 8'd0 :
                        (hs_p && step_number != 8'd99) ? step_number + 1'b1 : step_number;
         q_ovf       <= push_req && full && !hs_p;
      end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: randomized bench for move_scheduler against a queue/LFSR reference model.
module tb_move_scheduler;
   logic       clk_d = 1'b0, rst = 1'b0;
   logic [1:0] game_status = 2'b00;
   logic [3:0] act_flag = 4'h0;
   logic       random_sw = 1'b0, mv_ready = 1'b0;
   logic       mv_valid, mv_scramble, scramble_done, q_ovf;
   logic [1:0] mv_dir;
   logic [7:0] step_number;

   int         n_pass = 0, n_chk = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   int         m_q[$];
   bit         m_vis = 0;
   int         m_steps = 0;
   logic [1:0] cur[$], run1[$];

   move_scheduler dut (
      .clk_d(clk_d), .rst(rst), .game_status(game_status), .act_flag(act_flag),
      .random_sw(random_sw), .mv_ready(mv_ready), .mv_valid(mv_valid), .mv_dir(mv_dir),
      .mv_scramble(mv_scramble), .scramble_done(scramble_done), .step_number(step_number), .q_ovf(q_ovf)
   );

   always #5 clk_d = ~clk_d;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk_d);
      #1;
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Full scramble, or aborted into PLAY after abort_at handshakes.
   task automatic run_scramble(input int abort_at);
      int hs = 0, guard = 0;
      bit first = 1;
      logic [1:0] prev = 2'b00, d;
      cur.delete();
      m_steps = 0;
      random_sw = 1'b1;
      mv_ready = 1'b0;
      game_status = 2'b10;
      tick;
      check("init_valid", mv_valid, 0);
      tick;
      while (hs < 16 && guard < 400) begin
         guard++;
         d = m_lfsr[1:0];
         if (!first && d == (prev ^ 2'b01)) d ^= 2'b10;
         check("scr_valid", mv_valid, 1);
         check("scr_flag", mv_scramble, 1);
         check("scr_dir", mv_dir, d);
         if (abort_at != 0 && hs == abort_at) begin
            mv_ready = 1'b0;
            game_status = 2'b01;
            tick;
            check("abort_valid", mv_valid, 0);
            check("abort_done", scramble_done, 0);
            m_q.delete();
            m_vis = 0;
            return;
         end
         mv_ready = ($urandom_range(0, 3) != 0);
         tick;
         if (mv_ready) begin
            cur.push_back(d);
            prev = d;
            first = 0;
            hs++;
            m_lfsr = lfsr_next(m_lfsr);
         end
      end
      mv_ready = 1'b0;
      check("scr_count", hs, 16);
      check("scr_tail_valid", mv_valid, 0);
      check("scr_tail_done", scramble_done, 0);
      tick;
      check("scr_done", scramble_done, 1);
      check("scr_done_valid", mv_valid, 0);
      check("scr_step", step_number, 0);
   endtask

   // One PLAY cycle: apply inputs across an edge and compare with the queue model.
   task automatic play(input logic [3:0] act, input logic rdy);
      int n_old;
      bit hs, ovf = 0;
      act_flag = act;
      mv_ready = rdy;
      tick;
      act_flag = 4'h0;
      hs = m_vis && rdy;
      if (hs) begin
         void'(m_q.pop_front());
         m_steps++;
      end
      n_old = m_q.size();
      if (act != 4'h0) begin
         if (n_old < 4) begin
            for (int i = 0; i < 4; i++)
               if (act[i]) begin
                  m_q.push_back(i);
                  break;
               end
         end else ovf = 1;
      end
      m_vis = n_old > 0;
      check("play_valid", mv_valid, m_vis);
      if (m_vis) check("play_dir", mv_dir, m_q[0]);
      check("play_ovf", q_ovf, ovf);
      check("play_step", step_number, m_steps > 99 ? 99 : m_steps);
      check("play_scr", mv_scramble, 0);
   endtask

   initial begin
      int same;
      logic [3:0] a;
      #2;
      check("rst_valid", mv_valid, 0);
      check("rst_done", scramble_done, 0);
      tick;
      tick;
      rst = 1'b1;
      tick;
      check("idle_valid", mv_valid, 0);
      check("idle_dir", mv_dir, 0);
      check("idle_step", step_number, 0);
      check("idle_ovf", q_ovf, 0);

      run_scramble(0);
      check("first_dir", cur[0], 2'b01);
      run1 = cur;
      game_status = 2'b00;
      tick;
      check("idle2_done", scramble_done, 0);

      run_scramble(5);
      play(4'h1, 0);
      play(4'h2, 0);
      play(4'h4, 0);
      play(4'h8, 0);
      play(4'h1, 0);
      for (int i = 0; i < 5; i++) play(4'h0, 1);
      check("step4", step_number, 4);
      play(4'b1010, 0);
      play(4'h0, 1);
      play(4'h0, 1);
      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         play(a, $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 105; i++) play(4'(1 << $urandom_range(0, 3)), 1);
      for (int i = 0; i < 5; i++) play(4'h0, 1);
      check("sat_step", step_number, 99);

      game_status = 2'b11;
      tick;
      check("won_valid", mv_valid, 0);
      check("won_step", step_number, 99);
      act_flag = 4'hF;
      tick;
      act_flag = 4'h0;
      check("won_ovf", q_ovf, 0);
      check("won_valid2", mv_valid, 0);
      game_status = 2'b00;
      tick;
      check("idle_clear", step_number, 0);

      run_scramble(0);
      same = 0;
      for (int i = 0; i < 16; i++) if (run1[i] == cur[i]) same++;
      check("rescramble_differs", same == 16, 0);

      game_status = 2'b00;
      tick;
      random_sw = 1'b0;
      game_status = 2'b10;
      tick;
      check("nosw_entry_done", scramble_done, 0);
      tick;
      check("nosw_done", scramble_done, 1);
      check("nosw_valid", mv_valid, 0);

      game_status = 2'b00;
      tick;
      random_sw = 1'b1;
      mv_ready = 1'b0;
      game_status = 2'b10;
      tick;
      tick;
      check("pre_rst_valid", mv_valid, 1);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", mv_valid, 0);
      check("arst_scr", mv_scramble, 0);
      check("arst_dir", mv_dir, 0);
      check("arst_done", scramble_done, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
